// File: rtl/fei4_rx_arbiter_if.sv
// ============================================================================
// fei4_rx_arbiter_if : register bus, channel FIFO and readout port bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface fei4_rx_arbiter_if #(
  parameter int CHANNELS = 4
);
  logic [15:0]            BUS_ADD;
  logic [7:0]             BUS_DATA_IN;
  logic [7:0]             BUS_DATA_OUT;
  logic                   BUS_WR;
  logic                   BUS_RD;
  logic [CHANNELS-1:0]    CH_FIFO_EMPTY;
  logic [24*CHANNELS-1:0] CH_FIFO_DATA;
  logic [CHANNELS-1:0]    CH_FIFO_READ;
  logic                   FIFO_READ;
  logic                   FIFO_EMPTY;
  logic [31:0]            FIFO_DATA;

  modport master (
    output BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD, CH_FIFO_EMPTY, CH_FIFO_DATA, FIFO_READ,
    input  BUS_DATA_OUT, CH_FIFO_READ, FIFO_EMPTY, FIFO_DATA
  );

  modport slave (
    input  BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD, CH_FIFO_EMPTY, CH_FIFO_DATA, FIFO_READ,
    output BUS_DATA_OUT, CH_FIFO_READ, FIFO_EMPTY, FIFO_DATA
  );
endinterface

`default_nettype wire

// File: rtl/fei4_rx_arbiter.sv
// ============================================================================
// fei4_rx_arbiter : round-robin merge of per-link FE FIFOs into a tagged stream
// Rev 1.0
// ============================================================================
`default_nettype none

module fei4_rx_arbiter #(
  parameter int CHANNELS = 4
) (
  input  logic                BUS_CLK,
  input  logic                BUS_RST,
  fei4_rx_arbiter_if.slave    bus
);

  localparam logic [CHANNELS-1:0] ONE_HOT0 = CHANNELS'(1);

  logic                rst_int;
  logic                soft_rst_q;

  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [2:0]          ptr_q, ptr_d;
  logic                valid_q, valid_d;
  logic [31:0]         data_q, data_d;
  logic [7:0]          rd_q, rd_d;
  logic [7:0]          cnt_q [CHANNELS];
  logic [7:0]          cnt_d [CHANNELS];

  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] req_rot;
  logic [CHANNELS-1:0] pop;
  logic [3:0]          cand;
  logic [2:0]          gnt;
  logic                gnt_found;
  logic                load;
  logic [23:0]         sel_data;
  logic                unused_ok;

  // Soft reset is a registered strobe, so it acts exactly like BUS_RST one cycle later
  assign rst_int   = BUS_RST | soft_rst_q;
  assign unused_ok = ^{bus.BUS_RD, bus.BUS_DATA_IN};

  always_comb begin
    req       = mask_q & ~bus.CH_FIFO_EMPTY;
    gnt_found = 1'b0;
    gnt       = '0;
    cand      = '0;
    req_rot   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = {1'b0, ptr_q} + 4'(i);
      if (cand >= 4'(CHANNELS)) cand = cand - 4'(CHANNELS);
      req_rot = req >> cand;
      if (!gnt_found && req_rot[0]) begin
        gnt_found = 1'b1;
        gnt       = cand[2:0];
      end
    end
  end

  assign load     = !rst_int && (!valid_q || bus.FIFO_READ) && gnt_found;
  assign pop      = load ? (ONE_HOT0 << gnt) : '0;
  assign sel_data = 24'(bus.CH_FIFO_DATA >> (24 * gnt));

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    rd_d    = '0;

    if (load) begin
      valid_d = 1'b1;
      data_d  = {5'b0, gnt, sel_data};
      ptr_d   = (gnt == 3'(CHANNELS - 1)) ? 3'd0 : gnt + 3'd1;
    end else if (bus.FIFO_READ) begin
      valid_d = 1'b0;
    end

    if (bus.BUS_WR && bus.BUS_ADD == 16'd1) mask_d = bus.BUS_DATA_IN[CHANNELS-1:0];

    // Clear is evaluated last so a same-cycle write beats the increment
    for (int n = 0; n < CHANNELS; n++) begin
      if (load && gnt == 3'(n) && cnt_q[n] != 8'hFF) cnt_d[n] = cnt_q[n] + 8'd1;
      if (bus.BUS_WR && bus.BUS_ADD == 16'(3 + n)) cnt_d[n] = '0;
    end

    case (bus.BUS_ADD)
      16'd1:   rd_d = 8'(mask_q);
      16'd2:   rd_d = {6'b0, |(~bus.CH_FIFO_EMPTY), valid_q};
      default: begin
        for (int n = 0; n < CHANNELS; n++) begin
          if (bus.BUS_ADD == 16'(3 + n)) rd_d = cnt_q[n];
        end
      end
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) soft_rst_q <= 1'b0;
    else         soft_rst_q <= bus.BUS_WR && (bus.BUS_ADD == 16'd0);

    if (rst_int) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ptr_q   <= '0;
      mask_q  <= '1;
      rd_q    <= '0;
      for (int n = 0; n < CHANNELS; n++) cnt_q[n] <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      rd_q    <= rd_d;
      for (int n = 0; n < CHANNELS; n++) cnt_q[n] <= cnt_d[n];
    end
  end

  assign bus.BUS_DATA_OUT = rd_q;
  assign bus.CH_FIFO_READ = pop;
  assign bus.FIFO_EMPTY   = ~valid_q;
  assign bus.FIFO_DATA    = data_q;

endmodule

`default_nettype wire

// File: tb/tb_fei4_rx_arbiter.sv
// ============================================================================
// tb_fei4_rx_arbiter : directed self-checking bench with queue-based channel FIFOs
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fei4_rx_arbiter;

  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fei4_rx_arbiter_if #(.CHANNELS(CH)) bus ();

  fei4_rx_arbiter #(.CHANNELS(CH)) dut (
    .BUS_CLK (clk),
    .BUS_RST (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0]   chq [CH][$];
  logic [CH-1:0] pend;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] word(input int n, input int k);
    return {4'hA, 4'(n), 16'(k)};
  endfunction

  function automatic logic [31:0] tagw(input int n, input logic [23:0] w);
    return {5'b0, 3'(n), w};
  endfunction

  task automatic refresh();
    for (int n = 0; n < CH; n++) begin
      bus.CH_FIFO_EMPTY[n] = (chq[n].size() == 0);
      bus.CH_FIFO_DATA[24*n +: 24] = (chq[n].size() != 0) ? chq[n][0] : 24'h0;
    end
  endtask

  // Channel FIFO model: pops granted at the edge are applied 2 time units after it
  initial begin
    refresh();
    forever begin
      @(negedge clk);
      pend = bus.CH_FIFO_READ;
      check("pop_onehot", 32'($countones(pend) <= 1), 32'd1);
      @(posedge clk);
      #2;
      for (int n = 0; n < CH; n++) begin
        if (pend[n] === 1'b1) begin
          check("pop_nonempty", 32'(chq[n].size() != 0), 32'd1);
          if (chq[n].size() != 0) void'(chq[n].pop_front());
        end
      end
      refresh();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cyc();
    bus.BUS_WR = 1'b1; bus.BUS_ADD = a; bus.BUS_DATA_IN = d;
    cyc();
    bus.BUS_WR = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
    cyc();
    bus.BUS_ADD = a; bus.BUS_RD = 1'b1;
    cyc();
    bus.BUS_RD = 1'b0;
    check(tag, 32'(bus.BUS_DATA_OUT), 32'(exp));
  endtask

  task automatic drain();
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    bus.FIFO_READ = 1'b1;
    while (n < 2000 && !done) begin
      cyc();
      n++;
      done = (chq[0].size() == 0) && (chq[1].size() == 0) && (chq[2].size() == 0) &&
             (chq[3].size() == 0) && (bus.FIFO_EMPTY === 1'b1);
    end
    repeat (3) cyc();
    bus.FIFO_READ = 1'b0;
    check("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.BUS_ADD = '0; bus.BUS_DATA_IN = '0; bus.BUS_WR = 1'b0; bus.BUS_RD = 1'b0;
    bus.FIFO_READ = 1'b0;

    // Reset state, with channel words already waiting
    repeat (2) cyc();
    for (int n = 0; n < CH; n++) for (int k = 0; k < 2; k++) chq[n].push_back(word(n, k));
    cyc();
    @(negedge clk);
    check("rst_empty",   32'(bus.FIFO_EMPTY),   32'd1);
    check("rst_data",    bus.FIFO_DATA,         32'd0);
    check("rst_busout",  32'(bus.BUS_DATA_OUT), 32'd0);
    check("rst_chread",  32'(bus.CH_FIFO_READ), 32'd0);

    // 1: round robin, back-to-back
    cyc();
    rst = 1'b0; bus.FIFO_READ = 1'b1;
    @(negedge clk);
    check("t1_first_gnt", 32'(bus.CH_FIFO_READ), 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t1_order", bus.FIFO_DATA, tagw(k % 4, word(k % 4, k / 4)));
    end
    @(negedge clk);
    check("t1_empty_after", 32'(bus.FIFO_EMPTY), 32'd1);
    cyc();
    bus.FIFO_READ = 1'b0;
    rd("t1_cnt_ch0", 16'd3, 8'd2);
    rd("t1_cnt_ch3", 16'd6, 8'd2);

    // 2: single channel, no downstream read
    cyc();
    for (int k = 0; k < 3; k++) chq[2].push_back(word(2, 10 + k));
    @(negedge clk);
    check("t2_pop", 32'(bus.CH_FIFO_READ), 32'd4);
    @(negedge clk);
    check("t2_no_pop",  32'(bus.CH_FIFO_READ), 32'd0);
    check("t2_nonempty", 32'(bus.FIFO_EMPTY),  32'd0);
    check("t2_data",    bus.FIFO_DATA, tagw(2, word(2, 10)));
    @(negedge clk);
    check("t2_no_pop2", 32'(bus.CH_FIFO_READ), 32'd0);
    rd("t2_status", 16'd2, 8'h03);
    cyc();
    bus.FIFO_READ = 1'b1;
    @(negedge clk);
    check("t2_pop_on_read", 32'(bus.CH_FIFO_READ), 32'd4);
    cyc();
    bus.FIFO_READ = 1'b0;
    @(negedge clk);
    check("t2_next_word", bus.FIFO_DATA, tagw(2, word(2, 11)));
    drain();

    // 3: mask 0x05 -> only ch0/ch2, alternating
    wr(16'd1, 8'h05);
    cyc();
    for (int n = 0; n < CH; n++) for (int k = 0; k < 3; k++) chq[n].push_back(word(n, 20 + k));
    bus.FIFO_READ = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t3_gnt", 32'(bus.CH_FIFO_READ), (k % 2 == 0) ? 32'd1 : 32'd4);
    end
    @(negedge clk);
    check("t3_masked_idle", 32'(bus.CH_FIFO_READ), 32'd0);
    repeat (2) cyc();
    bus.FIFO_READ = 1'b0;
    rd("t3_mask_rd", 16'd1, 8'h05);
    rd("t3_cnt_ch0", 16'd3, 8'd5);
    rd("t3_cnt_ch1", 16'd4, 8'd2);

    // 4: counter saturation and clear-wins
    wr(16'd1, 8'h02);
    cyc();
    for (int k = 0; k < 300; k++) chq[1].push_back(word(1, 100 + k));
    bus.FIFO_READ = 1'b1;
    repeat (270) cyc();
    bus.FIFO_READ = 1'b0;
    rd("t4_cnt_sat", 16'd4, 8'd255);
    cyc();
    bus.BUS_WR = 1'b1; bus.BUS_ADD = 16'd4; bus.FIFO_READ = 1'b1;
    @(negedge clk);
    check("t4_load_in_clr", 32'(bus.CH_FIFO_READ), 32'd2);
    cyc();
    bus.BUS_WR = 1'b0; bus.FIFO_READ = 1'b0;
    rd("t4_cnt_clr", 16'd4, 8'd0);

    // 5: soft reset with a held word and pending channels
    cyc();
    chq[0].push_back(word(0, 50));
    wr(16'd1, 8'h0F);
    cyc();
    bus.BUS_WR = 1'b1; bus.BUS_ADD = 16'd0;
    @(negedge clk);
    check("t5_held", 32'(bus.FIFO_EMPTY), 32'd0);
    cyc();
    bus.BUS_WR = 1'b0;
    @(negedge clk);
    check("t5_rst_no_pop", 32'(bus.CH_FIFO_READ), 32'd0);
    cyc();
    @(negedge clk);
    check("t5_empty",     32'(bus.FIFO_EMPTY),   32'd1);
    check("t5_first_gnt", 32'(bus.CH_FIFO_READ), 32'd1);
    rd("t5_cnt_ch0", 16'd3, 8'd1);
    rd("t5_cnt_ch1", 16'd4, 8'd0);
    rd("t5_mask",    16'd1, 8'h0F);
    rd("t5_unused",  16'd7, 8'h00);

    // 6: downstream read while empty is ignored
    drain();
    cyc();
    chq[2].push_back(word(2, 99));
    bus.FIFO_READ = 1'b1;
    repeat (3) cyc();
    bus.FIFO_READ = 1'b0;
    @(negedge clk);
    check("t6_empty", 32'(bus.FIFO_EMPTY), 32'd1);
    check("t6_hold",  bus.FIFO_DATA, tagw(2, word(2, 99)));
    cyc();
    bus.FIFO_READ = 1'b1;
    @(negedge clk);
    check("t6_no_pop", 32'(bus.CH_FIFO_READ), 32'd0);
    cyc();
    bus.FIFO_READ = 1'b0;
    @(negedge clk);
    check("t6_still_empty", 32'(bus.FIFO_EMPTY), 32'd1);
    check("t6_data_kept",   bus.FIFO_DATA, tagw(2, word(2, 99)));
    rd("t6_status", 16'd2, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
